// File: rtl/alu_ctrl_pkg.sv
// Shared opcode and phase-index constants for the ALU phase controller.
package alu_ctrl_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int NUM_PH = 6;
    localparam int PH_FI0 = 0;
    localparam int PH_FI1 = 1;
    localparam int PH_FI2 = 2;
    localparam int PH_FI3 = 3;
    localparam int PH_FI4 = 4;
    localparam int PH_FI5 = 5;
endpackage

// File: rtl/alu_iter_cnt.sv
// Multiply iteration counter: clear, increment, saturate at WIDTH-1 with terminal count.
module alu_iter_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    assign tc = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !tc)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/alu_phase_ctrl.sv
// Decodes sequencer phase, latched opcode and datapath status into ALU strobes;
// owns BUSY/ERR state and requests loop exit via END.
module alu_phase_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       fi0,
    input  logic       fi1,
    input  logic       fi2,
    input  logic       fi3,
    input  logic       fi4,
    input  logic       fi5,
    input  logic [1:0] OP,
    input  logic       Q0,
    output logic       LD_B,
    output logic       LD_Q,
    output logic       CLR_A,
    output logic       ADD_EN,
    output logic       SUB_EN,
    output logic       SHR,
    output logic       WR_RES,
    output logic       DONE,
    output logic       END,
    output logic       BUSY,
    output logic       ERR
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [NUM_PH-1:0] ph;
    logic [1:0]        op_r;
    logic              busy_r;
    logic              err_r;
    logic [CNT_W-1:0]  cnt;
    logic              tc;
    logic              err_set;

    assign ph      = {fi5, fi4, fi3, fi2, fi1, fi0};
    assign err_set = !$onehot(ph) || (ph[PH_FI1] && OP == OP_RSV);

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_r   <= OP_ADD;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            // fi1 always re-arms, even mid-operation (restart without fi5)
            if (ph[PH_FI1]) begin
                op_r   <= OP;
                busy_r <= 1'b1;
            end else if (ph[PH_FI5]) begin
                busy_r <= 1'b0;
            end
            if (err_set)
                err_r <= 1'b1;
        end
    end

    alu_iter_cnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (ph[PH_FI1]),
        .inc (ph[PH_FI3] && op_r == OP_MUL),
        .cnt (cnt),
        .tc  (tc)
    );

    always_comb begin
        LD_B   = 1'b0;
        LD_Q   = 1'b0;
        CLR_A  = 1'b0;
        ADD_EN = 1'b0;
        SUB_EN = 1'b0;
        SHR    = 1'b0;
        WR_RES = 1'b0;
        DONE   = 1'b0;
        END    = 1'b0;
        if (!RST) begin
            // an error freezes the datapath but still lets the sequencer drain
            if (!err_r) begin
                LD_B   = ph[PH_FI1];
                LD_Q   = ph[PH_FI1];
                CLR_A  = ph[PH_FI1];
                ADD_EN = ph[PH_FI2] && (op_r == OP_ADD || (op_r == OP_MUL && Q0));
                SUB_EN = ph[PH_FI2] && op_r == OP_SUB;
                SHR    = ph[PH_FI3] && op_r == OP_MUL;
                WR_RES = ph[PH_FI4];
            end
            DONE = ph[PH_FI5];
            END  = (ph[PH_FI3] && (op_r != OP_MUL || tc)) || (err_r && busy_r);
        end
    end

    assign BUSY = busy_r && !RST;
    assign ERR  = err_r && !RST;
endmodule

// File: tb/tb_alu_phase_ctrl.sv
// Directed scoreboard bench for alu_phase_ctrl: driver queues expected strobes, monitor checks.
module tb_alu_phase_ctrl;
    logic clk, rst;
    logic fi0, fi1, fi2, fi3, fi4, fi5;
    logic [1:0] op;
    logic q0;
    logic ld_b, ld_q, clr_a, add_en, sub_en, shr, wr_res, done_s, end_s, busy, err;

    alu_phase_ctrl #(.WIDTH(8)) dut (
        .CLK(clk), .RST(rst),
        .fi0(fi0), .fi1(fi1), .fi2(fi2), .fi3(fi3), .fi4(fi4), .fi5(fi5),
        .OP(op), .Q0(q0),
        .LD_B(ld_b), .LD_Q(ld_q), .CLR_A(clr_a), .ADD_EN(add_en), .SUB_EN(sub_en),
        .SHR(shr), .WR_RES(wr_res), .DONE(done_s), .END(end_s), .BUSY(busy), .ERR(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {LD_B,LD_Q,CLR_A,ADD_EN,SUB_EN,SHR,WR_RES,DONE,END,BUSY,ERR}
    localparam logic [10:0] M_LD   = 11'b111_0000_0000;
    localparam logic [10:0] M_ADD  = 11'b000_1000_0000;
    localparam logic [10:0] M_SUB  = 11'b000_0100_0000;
    localparam logic [10:0] M_SHR  = 11'b000_0010_0000;
    localparam logic [10:0] M_WR   = 11'b000_0001_0000;
    localparam logic [10:0] M_DONE = 11'b000_0000_1000;
    localparam logic [10:0] M_END  = 11'b000_0000_0100;
    localparam logic [10:0] M_BUSY = 11'b000_0000_0010;
    localparam logic [10:0] M_ERR  = 11'b000_0000_0001;

    localparam logic [5:0] F0 = 6'b000001, F1 = 6'b000010, F2 = 6'b000100;
    localparam logic [5:0] F3 = 6'b001000, F4 = 6'b010000, F5 = 6'b100000;

    typedef struct {
        logic [10:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails  = 0;

    logic [10:0] got;
    assign got = {ld_b, ld_q, clr_a, add_en, sub_en, shr, wr_res, done_s, end_s, busy, err};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (got !== e.exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] fi, input logic [1:0] o,
                        input logic q, input logic [10:0] exp, input string nm);
        exp_t item;
        @(posedge clk);
        #1;
        rst = r;
        {fi5, fi4, fi3, fi2, fi1, fi0} = fi;
        op = o;
        q0 = q;
        item.exp  = exp;
        item.name = nm;
        sb.push_back(item);
    endtask

    // MUL from fi1 through fi0; expected ADD_EN follows the Q bit of each iteration
    task automatic run_mul(input logic [7:0] qbits, input string nm);
        step(0, F1, 2'b10, 0, M_LD, {nm, "_fi1"});
        for (int i = 0; i < 8; i++) begin
            step(0, F2, 2'b10, qbits[i], M_BUSY | (qbits[i] ? M_ADD : 11'd0),
                 $sformatf("%s_fi2_%0d", nm, i));
            step(0, F3, 2'b10, qbits[i], M_BUSY | M_SHR | ((i == 7) ? M_END : 11'd0),
                 $sformatf("%s_fi3_%0d", nm, i));
        end
        step(0, F4, 2'b10, 0, M_WR | M_BUSY, {nm, "_fi4"});
        step(0, F5, 2'b10, 0, M_DONE | M_BUSY, {nm, "_fi5"});
        step(0, F0, 2'b10, 0, 11'd0, {nm, "_fi0"});
    endtask

    initial begin
        rst = 1'b1;
        {fi5, fi4, fi3, fi2, fi1, fi0} = 6'b0;
        op = 2'b00;
        q0 = 1'b0;

        // reset with random inputs, then idle after release
        repeat (2) step(1, 6'($urandom), 2'($urandom), 1'($urandom), 11'd0, "reset");
        step(0, F0, 2'b00, 0, 11'd0, "post_reset");

        // ADD pass
        step(0, F1, 2'b00, 0, M_LD, "add_fi1");
        step(0, F2, 2'b00, 0, M_ADD | M_BUSY, "add_fi2");
        step(0, F3, 2'b00, 0, M_END | M_BUSY, "add_fi3");
        step(0, F4, 2'b00, 0, M_WR | M_BUSY, "add_fi4");
        step(0, F5, 2'b00, 0, M_DONE | M_BUSY, "add_fi5");
        step(0, F0, 2'b00, 0, 11'd0, "add_fi0");

        // SUB pass
        step(0, F1, 2'b01, 1, M_LD, "sub_fi1");
        step(0, F2, 2'b01, 1, M_SUB | M_BUSY, "sub_fi2");
        step(0, F3, 2'b01, 1, M_END | M_BUSY, "sub_fi3");
        step(0, F4, 2'b01, 1, M_WR | M_BUSY, "sub_fi4");
        step(0, F5, 2'b01, 1, M_DONE | M_BUSY, "sub_fi5");
        step(0, F0, 2'b01, 1, 11'd0, "sub_fi0");

        // MUL, Q LSB-first 1,0,1,0,1,1,0,1
        run_mul(8'b1011_0101, "mul");

        // mid-operation reset in iteration 3, then a full fresh MUL
        step(0, F1, 2'b10, 0, M_LD, "mrst_fi1");
        for (int i = 0; i < 3; i++) begin
            step(0, F2, 2'b10, 1, M_ADD | M_BUSY, $sformatf("mrst_fi2_%0d", i));
            step(0, F3, 2'b10, 1, M_SHR | M_BUSY, $sformatf("mrst_fi3_%0d", i));
        end
        step(1, F2, 2'b10, 1, 11'd0, "mrst_pulse");
        step(0, F0, 2'b10, 0, 11'd0, "mrst_idle");
        run_mul(8'b0000_0000, "mul2");

        // restart at fi1 while busy: re-latch opcode, no error
        step(0, F1, 2'b10, 0, M_LD, "rs_fi1a");
        step(0, F2, 2'b10, 0, M_BUSY, "rs_fi2a");
        step(0, F3, 2'b10, 0, M_SHR | M_BUSY, "rs_fi3a");
        step(0, F1, 2'b00, 0, M_LD | M_BUSY, "rs_fi1b");
        step(0, F2, 2'b00, 0, M_ADD | M_BUSY, "rs_fi2b");
        step(0, F3, 2'b00, 0, M_END | M_BUSY, "rs_fi3b");
        step(0, F4, 2'b00, 0, M_WR | M_BUSY, "rs_fi4b");
        step(0, F5, 2'b00, 0, M_DONE | M_BUSY, "rs_fi5b");
        step(0, F0, 2'b00, 0, 11'd0, "rs_fi0b");

        // illegal phases: fi2 and fi3 together during MUL
        step(0, F1, 2'b10, 0, M_LD, "ill_fi1");
        step(0, F2, 2'b10, 1, M_ADD | M_BUSY, "ill_fi2");
        step(0, F3, 2'b10, 1, M_SHR | M_BUSY, "ill_fi3");
        step(0, F2 | F3, 2'b10, 1, M_ADD | M_SHR | M_BUSY, "ill_both");
        step(0, F2, 2'b10, 1, M_END | M_BUSY | M_ERR, "ill_err_fi2");
        step(0, F3, 2'b10, 1, M_END | M_BUSY | M_ERR, "ill_err_fi3");
        step(0, F4, 2'b10, 1, M_END | M_BUSY | M_ERR, "ill_err_fi4");
        step(0, F5, 2'b10, 1, M_DONE | M_END | M_BUSY | M_ERR, "ill_err_fi5");
        step(0, F0, 2'b10, 0, M_ERR, "ill_err_fi0a");
        step(0, F0, 2'b10, 0, M_ERR, "ill_err_fi0b");
        step(1, F0, 2'b00, 0, 11'd0, "ill_rst");
        step(0, F0, 2'b00, 0, 11'd0, "ill_clear");

        // reserved opcode at fi1
        step(0, F1, 2'b11, 0, M_LD, "rsv_fi1");
        step(0, F2, 2'b11, 1, M_END | M_BUSY | M_ERR, "rsv_fi2");
        step(0, F3, 2'b11, 1, M_END | M_BUSY | M_ERR, "rsv_fi3");
        step(0, F4, 2'b11, 0, M_END | M_BUSY | M_ERR, "rsv_fi4");
        step(0, F5, 2'b11, 0, M_DONE | M_END | M_BUSY | M_ERR, "rsv_fi5");
        step(0, F0, 2'b11, 0, M_ERR, "rsv_fi0");
        step(1, F0, 2'b00, 0, 11'd0, "rsv_rst");

        // no phase line high
        step(0, 6'b0, 2'b00, 0, 11'd0, "nophase");
        step(0, F0, 2'b00, 0, M_ERR, "nophase_err");
        step(1, F0, 2'b00, 0, 11'd0, "nophase_rst");
        step(0, F0, 2'b00, 0, 11'd0, "final_idle");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
